slice_scheduler: RTL and testbench

Top-level sequencer for the slicing machine. It takes a requested slice count and one ultrasonic length measurement, then divides the length into equal steps. For each slice it drives the track motor one step, waits a settle time and fires the cut motor. It sits between the user controls (start/pause/slice count) and the supersonic, track_driver and cut_driver handshakes.

---
 rtl/slice_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_slice_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_scheduler.sv
// Slicing machine sequencer: measure object length, divide it into equal steps,
// then run MOVE / SETTLE / CUT rounds for the requested number of slices.
module slice_scheduler #(
   parameter int CNT_W      = 12,
   parameter int SETTLE_CYC = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             pause_i,
   input  logic [4:0]       slice_num_i,
   output logic             meas_req_o,
   input  logic             meas_valid_i,
   input  logic [CNT_W-1:0] meas_cnt_i,
   output logic             move_req_o,
   output logic [CNT_W-1:0] move_steps_o,
   input  logic             move_done_i,
   output logic             cut_req_o,
   input  logic             cut_done_i,
   output logic             busy_o,
   output logic [4:0]       slices_done_o,
   output logic             finish_o,
   output logic             error_o
);

   localparam int DCW = $clog2(CNT_W + 1);
   localparam int SCW = $clog2(SETTLE_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_MEASURE, S_DIVIDE, S_MOVE, S_SETTLE, S_CUT, S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [4:0]       slice_num_q, slice_num_d;
   logic [CNT_W-1:0] quo_q, quo_d;
   logic [4:0]       rem_q, rem_d;
   logic [DCW-1:0]   div_cnt_q, div_cnt_d;
   logic [SCW-1:0]   settle_q, settle_d;
   logic [CNT_W-1:0] step_q, step_d;
   logic [4:0]       slices_done_q, slices_done_d;
   logic             error_q, error_d;
   logic             pend_q, pend_d;

   // Restoring divide datapath: quo_q starts as the dividend and is shifted
   // left, the quotient bits entering at the LSB.
   logic [5:0]       trial;
   logic             fits;
   logic [4:0]       rem_next;
   logic [CNT_W-1:0] quo_next;
   logic             awaited;
   logic             got;

   assign trial    = {rem_q, quo_q[CNT_W-1]};
   assign fits     = (trial >= {1'b0, slice_num_q});
   assign rem_next = fits ? 5'(trial - {1'b0, slice_num_q}) : trial[4:0];
   assign quo_next = {quo_q[CNT_W-2:0], fits};

   always_comb begin
      awaited = 1'b0;
      case (state_q)
         S_MEASURE: awaited = meas_valid_i;
         S_MOVE:    awaited = move_done_i;
         S_CUT:     awaited = cut_done_i;
         default:   awaited = 1'b0;
      endcase
   end

   assign got = awaited | pend_q;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      slice_num_d   = slice_num_q;
      quo_d         = quo_q;
      rem_d         = rem_q;
      div_cnt_d     = div_cnt_q;
      settle_d      = settle_q;
      step_d        = step_q;
      slices_done_d = slices_done_q;
      error_d       = error_q;
      pend_d        = pend_q;
      meas_req_o    = 1'b0;
      move_req_o    = 1'b0;
      cut_req_o     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               slice_num_d   = slice_num_i;
               error_d       = 1'b0;
               slices_done_d = 5'd0;
               if (slice_num_i == 5'd0) begin
                  error_d = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_MEASURE;
               end
            end
         end

         S_MEASURE: begin
            if (meas_valid_i) quo_d = meas_cnt_i;
            if (pause_i) begin
               pend_d = got;
            end else begin
               meas_req_o = ~pend_q;
               pend_d     = 1'b0;
               if (got) begin
                  rem_d     = 5'd0;
                  div_cnt_d = '0;
                  state_d   = S_DIVIDE;
               end
            end
         end

         S_DIVIDE: begin
            if (!pause_i) begin
               quo_d     = quo_next;
               rem_d     = rem_next;
               div_cnt_d = div_cnt_q + DCW'(1);
               if (div_cnt_q == DCW'(CNT_W - 1)) begin
                  step_d = quo_next;
                  if (quo_next == '0) begin
                     error_d = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     state_d = S_MOVE;
                  end
               end
            end
         end

         S_MOVE: begin
            if (pause_i) begin
               pend_d = got;
            end else begin
               move_req_o = ~pend_q;
               pend_d     = 1'b0;
               if (got) begin
                  settle_d = '0;
                  state_d  = S_SETTLE;
               end
            end
         end

         S_SETTLE: begin
            if (!pause_i) begin
               if (settle_q == SCW'(SETTLE_CYC - 1)) state_d = S_CUT;
               else                                 settle_d = settle_q + SCW'(1);
            end
         end

         S_CUT: begin
            if (pause_i) begin
               pend_d = got;
            end else begin
               cut_req_o = ~pend_q;
               pend_d    = 1'b0;
               if (got) begin
                  slices_done_d = slices_done_q + 5'd1;
                  state_d = (slices_done_q + 5'd1 == slice_num_q) ? S_DONE : S_MOVE;
               end
            end
         end

         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         slice_num_q   <= 5'd0;
         quo_q         <= '0;
         rem_q         <= 5'd0;
         div_cnt_q     <= '0;
         settle_q      <= '0;
         step_q        <= '0;
         slices_done_q <= 5'd0;
         error_q       <= 1'b0;
         pend_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         slice_num_q   <= slice_num_d;
         quo_q         <= quo_d;
         rem_q         <= rem_d;
         div_cnt_q     <= div_cnt_d;
         settle_q      <= settle_d;
         step_q        <= step_d;
         slices_done_q <= slices_done_d;
         error_q       <= error_d;
         pend_q        <= pend_d;
      end
   end

   assign move_steps_o  = step_q;
   assign slices_done_o = slices_done_q;
   assign error_o       = error_q;
   assign busy_o        = (state_q != S_IDLE);
   assign finish_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_slice_scheduler.sv
// Directed bench for slice_scheduler: normal run, error runs, pause with
// pending completions, and reset abort.
module tb_slice_scheduler;

   localparam int CNT_W      = 12;
   localparam int SETTLE_CYC = 4;

   logic             clk = 1'b0;
   logic             rst_n, start_i, pause_i;
   logic [4:0]       slice_num_i;
   logic             meas_req_o, meas_valid_i;
   logic [CNT_W-1:0] meas_cnt_i;
   logic             move_req_o, move_done_i;
   logic [CNT_W-1:0] move_steps_o;
   logic             cut_req_o, cut_done_i;
   logic             busy_o, finish_o, error_o;
   logic [4:0]       slices_done_o;

   int n_cmp = 0;
   int n_err = 0;

   slice_scheduler #(.CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .pause_i(pause_i),
      .slice_num_i(slice_num_i), .meas_req_o(meas_req_o),
      .meas_valid_i(meas_valid_i), .meas_cnt_i(meas_cnt_i),
      .move_req_o(move_req_o), .move_steps_o(move_steps_o),
      .move_done_i(move_done_i), .cut_req_o(cut_req_o),
      .cut_done_i(cut_done_i), .busy_o(busy_o),
      .slices_done_o(slices_done_o), .finish_o(finish_o), .error_o(error_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic sig(input int w);
      case (w)
         0:       return meas_req_o;
         1:       return move_req_o;
         2:       return cut_req_o;
         default: return finish_o;
      endcase
   endfunction

   // Bounded wait for a request; a timeout shows up as a failed comparison.
   task automatic wait_sig(input int w, input string tag, output int n);
      n = 0;
      while (!sig(w) && n < 100) begin
         step();
         n++;
      end
      check(tag, sig(w), 1);
   endtask

   task automatic run_to_move(input logic [4:0] num, input logic [CNT_W-1:0] cnt);
      int k;
      slice_num_i = num; start_i = 1'b1;
      step();
      start_i = 1'b0; meas_cnt_i = cnt; meas_valid_i = 1'b1;
      step();
      meas_valid_i = 1'b0;
      wait_sig(1, "to_move", k);
   endtask

   initial begin
      int n, mv, cr;
      rst_n = 1'b0; start_i = 1'b0; pause_i = 1'b0; slice_num_i = 5'd0;
      meas_valid_i = 1'b0; meas_cnt_i = '0; move_done_i = 1'b0; cut_done_i = 1'b0;
      step(); step();
      check("rst_busy", busy_o, 0);
      check("rst_reqs", {meas_req_o, move_req_o, cut_req_o}, 0);
      check("rst_slices", slices_done_o, 0);
      check("rst_finish", finish_o, 0);
      check("rst_error", error_o, 0);
      check("rst_steps", move_steps_o, 0);
      rst_n = 1'b1;
      step();

      // Normal run: 4 slices over 900 counts.
      slice_num_i = 5'd4; start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("t1_meas_req_next", meas_req_o, 1);
      check("t1_busy", busy_o, 1);
      step(); step();
      meas_cnt_i = 12'd900; meas_valid_i = 1'b1;
      step();
      meas_valid_i = 1'b0;
      check("t1_meas_req_drop", meas_req_o, 0);
      mv = 0;
      for (int i = 0; i < 11; i++) begin
         if (i == 4) begin start_i = 1'b1; slice_num_i = 5'd9; end
         step();
         start_i = 1'b0;
         if (move_req_o) mv++;
      end
      check("t1_div_no_early_move", mv, 0);
      step();
      check("t1_div_exit_move_req", move_req_o, 1);
      check("t1_step", move_steps_o, 225);
      for (int r = 0; r < 4; r++) begin
         step(); step();
         move_done_i = 1'b1;
         step();
         move_done_i = 1'b0;
         check("t1_move_req_drop", move_req_o, 0);
         n = 1;
         while (!cut_req_o && n < 50) begin
            step();
            n++;
            check("t1_onehot", $countones({meas_req_o, move_req_o, cut_req_o}) <= 1, 1);
         end
         check("t1_settle_cycles", n, SETTLE_CYC + 1);
         step(); step();
         cut_done_i = 1'b1;
         step();
         cut_done_i = 1'b0;
         check("t1_slices_done", slices_done_o, r + 1);
         if (r < 3) begin
            check("t1_next_move", move_req_o, 1);
            check("t1_no_finish", finish_o, 0);
         end else begin
            check("t1_finish", finish_o, 1);
            check("t1_error", error_o, 0);
         end
      end
      step();
      check("t1_finish_one_cycle", finish_o, 0);
      check("t1_idle", busy_o, 0);

      // slice_num = 0: immediate error finish, no measurement.
      slice_num_i = 5'd0; start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("t2_no_meas", meas_req_o, 0);
      check("t2_error", error_o, 1);
      check("t2_finish", finish_o, 1);
      step();
      check("t2_finish_drop", finish_o, 0);
      check("t2_idle", busy_o, 0);
      check("t2_error_sticky", error_o, 1);

      // step = floor(10/31) = 0: error, never moves.
      slice_num_i = 5'd31; start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("t3_error_cleared", error_o, 0);
      check("t3_meas_req", meas_req_o, 1);
      meas_cnt_i = 12'd10; meas_valid_i = 1'b1;
      step();
      meas_valid_i = 1'b0;
      mv = 0;
      for (int i = 0; i < 11; i++) begin
         step();
         if (move_req_o) mv++;
      end
      step();
      check("t3_finish", finish_o, 1);
      check("t3_error", error_o, 1);
      check("t3_no_move", mv + int'(move_req_o), 0);
      step();
      check("t3_idle", busy_o, 0);

      // Pause 20 cycles in SETTLE, then pause in CUT with a pending cut_done.
      run_to_move(5'd1, 12'd50);
      check("t4_step", move_steps_o, 50);
      move_done_i = 1'b1;
      step();
      move_done_i = 1'b0;
      n = 1;
      step();
      n++;
      pause_i = 1'b1;
      cr = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) cut_done_i = 1'b1;
         step();
         cut_done_i = 1'b0;
         n++;
         if (cut_req_o) cr++;
      end
      check("t4_paused_no_cut", cr, 0);
      pause_i = 1'b0;
      while (!cut_req_o && n < 60) begin
         step();
         n++;
      end
      check("t4_settle_delayed", n, SETTLE_CYC + 1 + 20);
      pause_i = 1'b1;
      #1;
      check("t4_cut_req_dropped", cut_req_o, 0);
      cut_done_i = 1'b1;
      step();
      cut_done_i = 1'b0;
      step(); step();
      check("t4_paused_hold", {cut_req_o, busy_o}, 1);
      check("t4_paused_slices", slices_done_o, 0);
      pause_i = 1'b0;
      #1;
      check("t4_no_reraise", cut_req_o, 0);
      step();
      check("t4_slices", slices_done_o, 1);
      check("t4_finish", finish_o, 1);
      step();

      // move_done arrives while paused: consumed on resume, no duplicate move.
      run_to_move(5'd2, 12'd20);
      check("t5_step", move_steps_o, 10);
      pause_i = 1'b1;
      #1;
      check("t5_move_req_dropped", move_req_o, 0);
      move_done_i = 1'b1;
      step();
      move_done_i = 1'b0;
      step(); step(); step();
      check("t5_paused_hold", {move_req_o, busy_o}, 1);
      pause_i = 1'b0;
      #1;
      check("t5_no_reraise", move_req_o, 0);
      step();
      n = 1;
      mv = int'(move_req_o);
      while (!cut_req_o && n < 50) begin
         step();
         n++;
         if (move_req_o) mv++;
      end
      check("t5_settle_after_pending", n, SETTLE_CYC + 1);
      check("t5_no_dup_move", mv, 0);
      step();
      cut_done_i = 1'b1;
      step();
      cut_done_i = 1'b0;
      check("t5_slices1", slices_done_o, 1);
      check("t5_second_move", move_req_o, 1);
      pause_i = 1'b1;
      step(); step(); step();
      check("t5_pause_move_low", move_req_o, 0);
      pause_i = 1'b0;
      #1;
      check("t5_move_reassert", move_req_o, 1);
      move_done_i = 1'b1;
      step();
      move_done_i = 1'b0;
      wait_sig(2, "t5_cut2", n);
      cut_done_i = 1'b1;
      step();
      cut_done_i = 1'b0;
      check("t5_slices2", slices_done_o, 2);
      check("t5_finish", finish_o, 1);
      step();

      // Reset while move_req_o is high, then a clean run.
      run_to_move(5'd3, 12'd30);
      check("t6_move_req", move_req_o, 1);
      rst_n = 1'b0;
      step();
      check("t6_abort_busy", busy_o, 0);
      check("t6_abort_reqs", {meas_req_o, move_req_o, cut_req_o}, 0);
      check("t6_abort_slices", slices_done_o, 0);
      check("t6_abort_finish", finish_o, 0);
      rst_n = 1'b1;
      step(); step();
      slice_num_i = 5'd1; start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("t6_meas_req", meas_req_o, 1);
      meas_cnt_i = 12'd7; meas_valid_i = 1'b1;
      step();
      meas_valid_i = 1'b0;
      wait_sig(1, "t6_move", n);
      check("t6_step", move_steps_o, 7);
      move_done_i = 1'b1;
      step();
      move_done_i = 1'b0;
      wait_sig(2, "t6_cut", n);
      cut_done_i = 1'b1;
      step();
      cut_done_i = 1'b0;
      check("t6_finish", finish_o, 1);
      check("t6_slices", slices_done_o, 1);
      check("t6_error", error_o, 0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
